// File: rtl/uart_test.sv
// Two free-running 8N1 transmitters sharing one bit timer; channel 1 is looped back into a receiver.
// Latency: a byte is reported on RXRDY/DATA_OUT 9.5*DIV+3 clocks after its start-bit edge on TX_1.
// Backpressure: none; transmitters run continuously and RXRDY is a single-clock strobe.
module uart_test #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] TX_data_0,
  input  logic [7:0] TX_data_1,
  output logic       TX_0,
  output logic       TX_1,
  output logic       TXRDY,
  output logic       RXRDY,
  output logic [7:0] DATA_OUT
);

  // Clocks per bit and the half-bit point used to centre the receiver on each bit.
  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Transmit side: one state machine and one bit timer drive both channels.
  tx_state_t      tx_state;
  logic [CW-1:0]  tx_cnt;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_sh_0;
  logic [7:0]     tx_sh_1;

  // Receive side.
  logic           rx_s1;
  logic           rx_s2;
  logic           rx_prev;
  rx_state_t      rx_state;
  logic [CW-1:0]  rx_cnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_sh;

  // Shared transmitter: advance one bit every DIV clocks, latch both bytes when leaving IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh_0  <= '0;
      tx_sh_1  <= '0;
      TX_0     <= 1'b1;
      TX_1     <= 1'b1;
      TXRDY    <= 1'b1;
    end else if (tx_cnt != DIV_LAST) begin
      tx_cnt <= tx_cnt + 1'b1;
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        TX_IDLE: begin
          tx_state <= TX_START;
          tx_sh_0  <= TX_data_0;
          tx_sh_1  <= TX_data_1;
          TX_0     <= 1'b0;
          TX_1     <= 1'b0;
          TXRDY    <= 1'b0;
        end
        TX_START: begin
          tx_state <= TX_DATA;
          tx_bit   <= '0;
          TX_0     <= tx_sh_0[0];
          TX_1     <= tx_sh_1[0];
          tx_sh_0  <= {1'b0, tx_sh_0[7:1]};
          tx_sh_1  <= {1'b0, tx_sh_1[7:1]};
        end
        TX_DATA: begin
          if (tx_bit == 3'd7) begin
            tx_state <= TX_STOP;
            TX_0     <= 1'b1;
            TX_1     <= 1'b1;
          end else begin
            tx_bit  <= tx_bit + 3'd1;
            TX_0    <= tx_sh_0[0];
            TX_1    <= tx_sh_1[0];
            tx_sh_0 <= {1'b0, tx_sh_0[7:1]};
            tx_sh_1 <= {1'b0, tx_sh_1[7:1]};
          end
        end
        TX_STOP: begin
          tx_state <= TX_IDLE;
          TX_0     <= 1'b1;
          TX_1     <= 1'b1;
          TXRDY    <= 1'b1;
        end
        default: begin
          tx_state <= TX_IDLE;
          TX_0     <= 1'b1;
          TX_1     <= 1'b1;
          TXRDY    <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchronizer on the looped-back line plus one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= TX_1;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver: find the start edge, confirm it at half-bit, then sample every DIV clocks at mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      RXRDY    <= 1'b0;
      DATA_OUT <= 8'h00;
    end else begin
      RXRDY <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              // Line went back high: treat as a glitch.
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            // A low stop bit is a framing error: the byte is dropped silently.
            if (rx_s2) begin
              DATA_OUT <= rx_sh;
              RXRDY    <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          rx_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_test.sv
// Randomized bench for uart_test: line waveforms and received bytes are predicted from frame
// arithmetic (frame start every 11*DIV clocks after an initial DIV-clock idle) and compared
// cycle by cycle; reset, mid-frame reset and mid-frame data changes are exercised.
module tb_uart_test;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 11 * DIV;
  localparam int RX_LAT   = 9 * DIV + DIV / 2 + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] TX_data_0 = 8'h00;
  logic [7:0] TX_data_1 = 8'h00;
  logic       TX_0;
  logic       TX_1;
  logic       TXRDY;
  logic       RXRDY;
  logic [7:0] DATA_OUT;

  uart_test #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .TX_data_0(TX_data_0),
    .TX_data_1(TX_data_1),
    .TX_0     (TX_0),
    .TX_1     (TX_1),
    .TXRDY    (TXRDY),
    .RXRDY    (RXRDY),
    .DATA_OUT (DATA_OUT)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         k = 0;            // rising edges since reset release
  logic [7:0] lat0 = 8'h00;     // byte in flight on channel 0
  logic [7:0] lat1 = 8'h00;     // byte in flight on channel 1
  logic [7:0] exp_dout = 8'h00; // last byte that should be on DATA_OUT
  int         pend_k[$];        // edge index at which each reception is due
  logic [7:0] pend_b[$];        // byte expected for that reception
  bit         prev_rx = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Expected line level after edge kk for a frame carrying byte b.
  function automatic logic exp_line(input int kk, input logic [7:0] b);
    int r;
    int bi;
    if (kk < DIV) return 1'b1;
    r  = (kk - DIV) % FRAME;
    bi = r / DIV;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    return 1'b1;
  endfunction

  function automatic logic exp_txrdy(input int kk);
    if (kk < DIV) return 1'b1;
    return (((kk - DIV) % FRAME) / DIV) == 10;
  endfunction

  // One clock: advance the model at the rising edge, compare outputs at the falling edge.
  task automatic step();
    @(posedge clk);
    k++;
    if (k >= DIV && ((k - DIV) % FRAME) == 0) begin
      lat0 = TX_data_0;
      lat1 = TX_data_1;
      pend_k.push_back(k + RX_LAT);
      pend_b.push_back(TX_data_1);
    end
    @(negedge clk);
    check("tx0_line", TX_0, exp_line(k, lat0));
    check("tx1_line", TX_1, exp_line(k, lat1));
    check("txrdy", TXRDY, exp_txrdy(k));
    if (RXRDY === 1'b1) begin
      if (pend_k.size() > 0 && !prev_rx && k >= pend_k[0] - 1 && k <= pend_k[0] + 1) begin
        check("rx_byte", DATA_OUT, pend_b[0]);
        exp_dout = pend_b[0];
        void'(pend_k.pop_front());
        void'(pend_b.pop_front());
      end else begin
        check("rxrdy_spurious", RXRDY, 0);
      end
    end else begin
      if (pend_k.size() > 0 && k > pend_k[0] + 1) begin
        check("rxrdy_missing", RXRDY, 1);
        void'(pend_k.pop_front());
        void'(pend_b.pop_front());
      end
      if (pend_k.size() == 0 || k < pend_k[0] - 1) begin
        check("data_out_hold", DATA_OUT, exp_dout);
      end
    end
    prev_rx = (RXRDY === 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx0"},   TX_0, 1);
    check({tag, "_tx1"},   TX_1, 1);
    check({tag, "_txrdy"}, TXRDY, 1);
    check({tag, "_rxrdy"}, RXRDY, 0);
    check({tag, "_dout"},  DATA_OUT, 8'h00);
  endtask

  // Assert reset (called at a falling edge), check outputs immediately and while held, then release.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    check_reset_vals("rst_now");
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_reset_vals("rst_hold");
    end
    rst = 1'b1;
    k        = 0;
    exp_dout = 8'h00;
    prev_rx  = 1'b0;
    pend_k.delete();
    pend_b.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the edge count lands on phase r_target of a frame (always reached within two frames).
  task automatic run_to_phase(input int r_target);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(k >= DIV && ((k - DIV) % FRAME) == r_target) && guard < 2 * FRAME + DIV);
  endtask

  initial begin
    int rst_at;
    #3;
    do_reset(10);

    // First frame interrupted by reset during DATA3: nothing may be received.
    TX_data_0 = 8'hFF;
    TX_data_1 = 8'h3C;
    run_to_phase(4 * DIV + 3);
    do_reset(4);

    // Steady loopback of 0x3C.
    run(3 * FRAME + DIV);

    // Change channel 1 mid-frame: current frame keeps 0x3C, next carries 0xA5.
    run_to_phase(5 * DIV);
    TX_data_1 = 8'hA5;
    run(2 * FRAME);

    // Random data changes at random moments, with one random reset somewhere in the middle.
    rst_at = $urandom_range(FRAME, 8 * FRAME);
    for (int i = 0; i < 10 * FRAME; i++) begin
      step();
      if ($urandom_range(0, 99) == 0) TX_data_0 = 8'($urandom);
      if ($urandom_range(0, 99) == 0) TX_data_1 = 8'($urandom);
      if (i == rst_at) do_reset(2 + $urandom_range(0, 3));
    end

    // Let the last outstanding reception resolve.
    run(FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_test.md
UART_TEST -- requirements
Module: uart_test

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, gives the system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, gives the line rate in bit/s.
REQ-003 Derived constant DIV = CLK_FREQ/BAUD, integer-truncated, gives clocks per bit (434 at defaults).
REQ-004 clk  input  1  single system clock; all state is on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 TX_data_0  input  8  byte transmitted repeatedly on TX_0.
REQ-007 TX_data_1  input  8  byte transmitted repeatedly on TX_1.
REQ-008 TX_0  output  1  serial line of channel 0; idle high.
REQ-009 TX_1  output  1  serial line of channel 1; idle high; also looped back internally to the receiver.
REQ-010 TXRDY  output  1  high while the channel-1 transmitter is in its idle gap.
REQ-011 RXRDY  output  1  one-clock pulse per valid byte received.
REQ-012 DATA_OUT  output  8  last valid received byte.

Function
REQ-013 Both transmitters SHALL use 8N1 framing: one start bit 0, 8 data bits LSB first, one stop bit 1, each bit exactly DIV clocks.
REQ-014 Each transmitter SHALL run the state sequence IDLE (DIV clocks, line high) -> START -> DATA0..DATA7 -> STOP -> IDLE, repeating forever, for a period of 11*DIV clocks.
REQ-015 Each transmitter SHALL latch its TX_data input on the clock that leaves IDLE for START.
REQ-016 Input changes during a frame SHALL NOT affect that frame; they take effect from the next frame.
REQ-017 Both channels SHALL share one bit-timing counter, so TX_0 and TX_1 frames start on the same clock.
REQ-018 TXRDY SHALL be 1 in the IDLE state of channel 1 and 0 from START through STOP.
REQ-019 The receiver input SHALL be TX_1, passed through a 2-flop synchronizer.
REQ-020 The receiver SHALL detect a falling edge while idle.
REQ-021 The receiver SHALL re-sample the start bit at DIV/2; if it reads 1, the receiver returns to idle (glitch reject).
REQ-022 After a valid start bit, the receiver SHALL sample each data bit every DIV clocks at mid-bit and shift it in LSB first.
REQ-023 The receiver SHALL sample the stop bit at mid-bit.
REQ-024 If the stop bit is 1, DATA_OUT SHALL load the byte and RXRDY SHALL be 1 for exactly one clock.
REQ-025 If the stop bit is 0 (framing error), the byte SHALL be discarded: DATA_OUT unchanged, no RXRDY pulse.
REQ-026 RXRDY SHALL assert 9.5*DIV + 3 clocks (±1) after the TX_1 start-bit falling edge, which is before the next frame's start bit.
REQ-027 DATA_OUT SHALL hold its value between valid receptions.

Reset
REQ-028 While rst=0: TX_0=1, TX_1=1, TXRDY=1, RXRDY=0, DATA_OUT=8'h00.
REQ-029 While rst=0, all counters and state machines SHALL be in IDLE with counts 0.
REQ-030 Reset asserted mid-frame SHALL force the lines high immediately and discard any partial received byte.
REQ-031 After rst rises, the first start bit SHALL occur DIV clocks later (one full IDLE period).

Verification
REQ-032 Reset: hold rst=0 for 10 clocks -> TX_0=TX_1=1, TXRDY=1, RXRDY=0, DATA_OUT=0x00.
REQ-033 TX_data_0=0xFF, 20 ns clock -> TX_0 low for 434 clocks from DIV clocks after release, then high for 10*434 clocks, repeating every 4774 clocks.
REQ-034 TX_data_1=0x3C -> TX_1 bit sequence 0,0,0,1,1,1,1,0,0,1 (start, data LSB first, stop), each 434 clocks; TXRDY low across those 4340 clocks.
REQ-035 Loopback with 0x3C -> one-clock RXRDY pulse about 4126 clocks after the start edge; DATA_OUT=0x3C; this repeats every frame.
REQ-036 Change TX_data_1 to 0xA5 mid-frame -> the current frame still decodes 0x3C; the next frame gives DATA_OUT=0xA5.
REQ-037 Pulse rst low during DATA3 -> lines go high at once, no RXRDY pulse, DATA_OUT keeps 0x00; normal frames resume after release.
